// File: rtl/freq_pkg.sv
// freq_pkg: shared constants and FSM state type for the frequency counter.
package freq_pkg;
  localparam int DIGITS_DEF = 8;
  localparam int BCD_W = 4;
  typedef enum logic {IDLE, COUNT} state_t;
endpackage

// File: rtl/freq_measure_bcd_digit.sv
// bcd_digit: one decade of a ripple-carry BCD counter with synchronous clear.
module bcd_digit
  import freq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic             cin,
  output logic [BCD_W-1:0] digit,
  output logic             cout
);
  assign cout = cin & (digit == BCD_W'(9));
  always_ff @(posedge clk or posedge rst)
    if (rst) digit <= '0;
    else if (clear) digit <= '0;
    else if (en && cin) digit <= cout ? '0 : digit + 1'b1;
endmodule

// File: rtl/freq_measure.sv
// freq_measure: counts synchronised sig_in rising edges inside each c_clk gate window, BCD result.
module freq_measure
  import freq_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                     sys_clk,
  input  logic                     reset,
  input  logic                     c_clk,
  input  logic                     sig_in,
  output logic [BCD_W*DIGITS-1:0]  freq_bcd,
  output logic                     valid,
  output logic                     overflow
);
  logic [2:0] sync;
  logic gate_r, primed, win_ovf, rise, fall, edge_det, sat, inc, done;
  logic [DIGITS:0] carry;
  logic [BCD_W*DIGITS-1:0] cnt;
  state_t state, state_n;
  // primed blocks a false rise when reset releases with the gate already high
  assign rise = primed & c_clk & ~gate_r;
  assign fall = ~c_clk & gate_r;
  assign edge_det = sync[1] & ~sync[2];
  assign sat = carry[DIGITS];
  assign carry[0] = 1'b1;
  always_comb begin
    state_n = (state == IDLE && rise) ? COUNT : (state == COUNT && fall) ? IDLE : state;
    done = (state == COUNT) & fall;
    inc = (state == COUNT) & ~fall & edge_det & ~sat;
  end
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      sync <= '0;
      gate_r <= 1'b0;
      primed <= 1'b0;
      state <= IDLE;
      win_ovf <= 1'b0;
      freq_bcd <= '0;
      valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      sync <= {sync[1:0], sig_in};
      gate_r <= c_clk;
      primed <= 1'b1;
      state <= state_n;
      valid <= done;
      if (rise) win_ovf <= 1'b0;
      else if (state == COUNT && !fall && edge_det && sat) win_ovf <= 1'b1;
      if (done) begin
        freq_bcd <= cnt;
        overflow <= win_ovf;
      end
    end
  end
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk(sys_clk),
      .rst(reset),
      .clear(rise),
      .en(inc),
      .cin(carry[i]),
      .digit(cnt[BCD_W*i +: BCD_W]),
      .cout(carry[i+1])
    );
  end
endmodule

// File: tb/tb_freq_measure.sv
// tb_freq_measure: directed plus random gate windows, checked against an edge-list window model.
module tb_freq_measure;
  logic sys_clk = 1'b0;
  logic reset = 1'b0;
  logic c_clk = 1'b0;
  logic sig_in = 1'b0;
  logic [31:0] f8;
  logic [7:0] f2;
  logic v8, v2, o8, o2;
  int vectors = 0;
  int fails = 0;
  int n = 0;
  int g = 0;
  int q[$];
  logic prev_c, prev_s, have_prev, open;
  logic exp_v, exp_o8, exp_o2;
  logic [63:0] exp_f8, exp_f2;
  int per, hi, len, ph, idl;

  always #5 sys_clk = ~sys_clk;

  freq_measure #(.DIGITS(8)) dut8 (
    .sys_clk(sys_clk), .reset(reset), .c_clk(c_clk), .sig_in(sig_in),
    .freq_bcd(f8), .valid(v8), .overflow(o8)
  );
  freq_measure #(.DIGITS(2)) dut2 (
    .sys_clk(sys_clk), .reset(reset), .c_clk(c_clk), .sig_in(sig_in),
    .freq_bcd(f2), .valid(v2), .overflow(o2)
  );

  function automatic logic [63:0] bcd(input int v, input int d);
    logic [63:0] r = '0;
    int cap = 1;
    for (int i = 0; i < d; i++) cap *= 10;
    if (v > cap - 1) v = cap - 1;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v /= 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      if (fails <= 20) $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic c, input logic s);
    int cnt;
    c_clk = c;
    sig_in = s;
    @(posedge sys_clk);
    exp_v = 1'b0;
    if (s && !prev_s) q.push_back(n);
    if (have_prev && c && !prev_c) begin
      open = 1'b1;
      g = n;
    end
    if (have_prev && !c && prev_c && open) begin
      cnt = 0;
      foreach (q[i]) if (q[i] + 2 > g && q[i] + 2 < n) cnt++;
      q.delete();
      open = 1'b0;
      exp_v = 1'b1;
      exp_f8 = bcd(cnt, 8);
      exp_o8 = cnt > 99999999;
      exp_f2 = bcd(cnt, 2);
      exp_o2 = cnt > 99;
    end
    prev_c = c;
    prev_s = s;
    have_prev = 1'b1;
    n++;
    #1;
    chk("valid8", 64'(v8), 64'(exp_v));
    chk("valid2", 64'(v2), 64'(exp_v));
    chk("freq8", 64'(f8), exp_f8);
    chk("freq2", 64'(f2), exp_f2);
    chk("ovf8", 64'(o8), 64'(exp_o8));
    chk("ovf2", 64'(o2), 64'(exp_o2));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_freq8", 64'(f8), 64'h0);
    chk("rst_freq2", 64'(f2), 64'h0);
    chk("rst_valid", 64'({v8, v2}), 64'h0);
    chk("rst_ovf", 64'({o8, o2}), 64'h0);
    q.delete();
    have_prev = 1'b0;
    prev_s = 1'b0;
    prev_c = 1'b0;
    open = 1'b0;
    exp_v = 1'b0;
    exp_f8 = '0;
    exp_f2 = '0;
    exp_o8 = 1'b0;
    exp_o2 = 1'b0;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    reset = 1'b0;
  endtask

  task automatic window(input int l, input int p, input int h, input int p0, input int idle);
    for (int i = 0; i < l; i++) step(1'b1, ((p0 + i) % p) < h);
    for (int i = 0; i < idle; i++) step(1'b0, 1'b0);
  endtask

  function automatic logic place(input int k);
    return (k >= -2 && k < 0) || (k >= 3 && k < 5) || (k >= 8 && k < 10) ||
           (k >= 13 && k < 15) || (k >= 18 && k < 20);
  endfunction

  initial begin
    #1;
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
    window(1000, 10, 5, 0, 20);
    chk("nominal_freq8", 64'(f8), 64'h100);
    chk("nominal_ovf8", 64'(o8), 64'h0);
    window(1500, 10, 5, 0, 20);
    chk("sat_freq2", 64'(f2), 64'h99);
    chk("sat_ovf2", 64'(o2), 64'h1);
    chk("sat_freq8", 64'(f8), 64'h150);
    window(70, 10, 5, 0, 20);
    chk("after_sat_freq2", 64'(f2), 64'h07);
    chk("after_sat_ovf2", 64'(o2), 64'h0);
    for (int i = 0; i < 500; i++) step(1'b1, (i % 10) < 5);
    do_reset();
    for (int i = 500; i < 1000; i++) step(1'b1, (i % 10) < 5);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
    chk("partial_freq8", 64'(f8), 64'h0);
    window(1000, 10, 5, 0, 20);
    chk("post_reset_freq8", 64'(f8), 64'h100);
    for (int k = -6; k < 26; k++) step(k >= 0 && k < 20, place(k));
    chk("placement_freq8", 64'(f8), 64'h3);
    window(4396, 4, 2, 0, 10);
    chk("carry_1099", 64'(f8), 64'h1099);
    window(4400, 4, 2, 0, 10);
    chk("carry_1100", 64'(f8), 64'h1100);
    repeat (10) begin
      per = $urandom_range(4, 20);
      hi = $urandom_range(2, per - 2);
      len = $urandom_range(30, 400);
      ph = $urandom_range(0, per - 1);
      idl = $urandom_range(3, 30);
      window(len, per, hi, ph, idl);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule

// File: doc/freq_measure.md
FREQ_MEASURE -- requirements
Module: freq_measure

Interface
REQ-001 SHALL have parameter DIGITS, default 8: number of BCD decade digits in the count and result.
REQ-002 SHALL have port sys_clk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port c_clk, input, 1 bit: gate signal from the gate-clock generator, synchronous to sys_clk. High means a measurement window is open.
REQ-005 SHALL have port sig_in, input, 1 bit: the signal being measured; asynchronous to sys_clk.
REQ-006 SHALL have port freq_bcd, output, 4*DIGITS bits: latched BCD count of the last completed window; digit 0 is bits [3:0].
REQ-007 SHALL have port valid, output, 1 bit: one-cycle pulse when freq_bcd and overflow update.
REQ-008 SHALL have port overflow, output, 1 bit: the last completed window's count exceeded the DIGITS capacity.

Function
REQ-009 SHALL synchronise sig_in through two flip-flops, then detect rising edges with one further register. Latency from sig_in edge to counted edge is 3 sys_clk cycles.
REQ-010 SHALL register c_clk into gate_r and derive events:
  - rise = c_clk & ~gate_r
  - fall = ~c_clk & gate_r
REQ-011 SHALL implement a 2-state FSM:
  - IDLE -> COUNT on rise.
  - COUNT -> IDLE on fall.
  - No other transitions.
REQ-012 SHALL clear the BCD counter to 0 in the rise cycle; an edge detected in that cycle is not counted.
REQ-013 SHALL, in COUNT with no fall event, increment the counter by 1 per detected edge. Increment is decimal: digit 9 -> 0 with carry into the next digit.
REQ-014 SHALL, on the fall cycle:
  - copy the counter into freq_bcd and the window overflow flag into overflow;
  - assert valid for exactly that one cycle;
  - not count an edge detected in that same cycle.
REQ-015 SHALL saturate the counter at all-nines: an edge arriving at all-nines leaves the counter unchanged and sets the window overflow flag. The flag is cleared on rise.
REQ-016 SHALL hold freq_bcd and overflow constant between valid pulses.
REQ-017 SHALL not count edges while in IDLE.
REQ-018 SHALL correctly count sig_in whose high and low phases are each at least 2 sys_clk periods. Behaviour for faster signals is not required.

Reset
REQ-019 SHALL, while reset is high, asynchronously force:
  - state = IDLE, counter = 0, window overflow flag = 0;
  - freq_bcd = 0, valid = 0, overflow = 0;
  - sync registers and gate_r = 0.
REQ-020 SHALL, if reset deasserts while c_clk is high, see gate_r go high one cycle later with no rise event. The partial window SHALL be discarded: no counting and no valid at its fall; counting starts at the next rise.
REQ-021 SHALL, on reset mid-window, abandon the window with no valid pulse; freq_bcd returns to 0.

Structure
REQ-022 SHALL place the default DIGITS value and the BCD digit width constant (4) in the shared package freq_pkg.
REQ-023 SHALL use one sub-module, bcd_digit:
  - inputs: clear, increment-enable, carry-in;
  - outputs: 4-bit digit, carry-out (asserted at 9 with carry-in).
REQ-024 SHALL instantiate DIGITS copies of bcd_digit, chained by carry. The saturation detect (all digits = 9) is done in freq_measure.

Verification
REQ-025 SHALL cover a nominal window: gate high 1000 cycles, sig_in period 10 cycles (5 high, 5 low). Required: freq_bcd = 0x00000100, overflow = 0, valid high for 1 cycle at the fall.
REQ-026 SHALL cover overflow with DIGITS = 2: 150 sig_in edges inside one window. Required: freq_bcd = 0x99, overflow = 1. The next window with 7 edges gives freq_bcd = 0x07, overflow = 0.
REQ-027 SHALL cover reset 500 cycles into a window with sig_in period 10. Required: all outputs 0 immediately; no valid at that window's fall; the next full 1000-cycle window gives 0x00000100.
REQ-028 SHALL cover reset released with c_clk high. Required: no valid at the first fall; the first valid follows the next complete rise-to-fall window.
REQ-029 SHALL cover edge placement: a synchronised edge coinciding with the fall cycle and one coinciding with the rise cycle are both excluded. A window with exactly 3 interior edges gives freq_bcd = 0x00000003.
REQ-030 SHALL cover a decimal carry chain: a window with 1099 edges gives freq_bcd = 0x00001099; a window with 1100 edges gives 0x00001100.
